// File: rtl/mux8x1_reg.sv
// Registered 8-to-1 word selector: two 4:1 stages feed a 2:1 stage, then one output register.
// The register carries a valid flag that marks each cycle following a capture.
module mux8x1_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    input  logic [WIDTH-1:0] i4,
    input  logic [WIDTH-1:0] i5,
    input  logic [WIDTH-1:0] i6,
    input  logic [WIDTH-1:0] i7,
    input  logic             s0,
    input  logic             s1,
    input  logic             s2,
    input  logic             en,
    output logic [WIDTH-1:0] y,
    output logic             y_valid
);

    logic [1:0]       sel_lo;
    logic [WIDTH-1:0] mux_lower;
    logic [WIDTH-1:0] mux_upper;
    logic [WIDTH-1:0] mux_out;

    assign sel_lo = {s1, s0};

    always_comb begin
        mux_lower = i0;
        case (sel_lo)
            2'd0:    mux_lower = i0;
            2'd1:    mux_lower = i1;
            2'd2:    mux_lower = i2;
            default: mux_lower = i3;
        endcase
    end

    always_comb begin
        mux_upper = i4;
        case (sel_lo)
            2'd0:    mux_upper = i4;
            2'd1:    mux_upper = i5;
            2'd2:    mux_upper = i6;
            default: mux_upper = i7;
        endcase
    end

    assign mux_out = s2 ? mux_upper : mux_lower;

    // Outputs come only from flops, so select/data changes never glitch y.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y       <= '0;
            y_valid <= 1'b0;
        end else begin
            y_valid <= en;
            if (en) begin
                y <= mux_out;
            end
        end
    end

endmodule

// File: tb/tb_mux8x1_reg.sv
// Bench for mux8x1_reg (WIDTH=8): directed scenarios plus random traffic against an
// array-indexed reference model delayed by one clock.
module tb_mux8x1_reg;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic [W-1:0] d [8];
    logic [2:0]   sel;
    logic         en;
    logic [W-1:0] y;
    logic         y_valid;

    logic [W-1:0] exp_y;
    logic         exp_v;
    int           checks;
    int           errors;

    mux8x1_reg #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .i0      (d[0]),
        .i1      (d[1]),
        .i2      (d[2]),
        .i3      (d[3]),
        .i4      (d[4]),
        .i5      (d[5]),
        .i6      (d[6]),
        .i7      (d[7]),
        .s0      (sel[0]),
        .s1      (sel[1]),
        .s2      (sel[2]),
        .en      (en),
        .y       (y),
        .y_valid (y_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; the model takes the value picked by index sel from the data array.
    task automatic tick();
        logic [W-1:0] pick;
        logic         take;
        pick = d[sel];
        take = en;
        @(posedge clk);
        if (rst) begin
            exp_y = '0;
            exp_v = 1'b0;
        end else begin
            exp_v = take;
            if (take) exp_y = pick;
        end
        @(negedge clk);
    endtask

    task automatic randomize_inputs();
        for (int n = 0; n < 8; n++) d[n] = W'($urandom);
        sel = 3'($urandom_range(0, 7));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        randomize_inputs();
        en = 1'b1;
        #1;
        checks++;
        if (y !== '0 || y_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_immediate: y=%h v=%b expected y=00 v=0", y, y_valid);
        end
        for (int k = 0; k < 3; k++) begin
            randomize_inputs();
            tick();
            checks++;
            if (y !== '0 || y_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_held: y=%h v=%b expected y=00 v=0", y, y_valid);
            end
        end
        rst = 1'b0;
        randomize_inputs();
        d[sel] = 8'h3C;
        en = 1'b1;
        tick();
        checks++;
        if (y !== 8'h3C || y_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_capture: y=%h v=%b expected y=3c v=1", y, y_valid);
        end
    endtask

    task automatic test_select_sweep();
        logic [7:0] pattern;
        pattern = 8'b0100_1101; // bit n is the value placed on input n
        for (int n = 0; n < 8; n++) d[n] = W'(pattern[n]);
        en = 1'b1;
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            tick();
            checks++;
            if (y !== W'(pattern[s]) || y_valid !== 1'b1 || y !== exp_y) begin
                errors++;
                $display("FAIL select_sweep sel=%0d: y=%h v=%b expected y=%h v=1", s, y, y_valid, W'(pattern[s]));
            end
        end
    endtask

    task automatic test_walking_one();
        logic [2:0] sels [3];
        logic [7:0] wants [3];
        sels[0] = 3'd5; wants[0] = 8'h20;
        sels[1] = 3'd7; wants[1] = 8'h80;
        sels[2] = 3'd0; wants[2] = 8'h01;
        for (int n = 0; n < 8; n++) d[n] = 8'h01 << n;
        en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sel = sels[k];
            tick();
            checks++;
            if (y !== wants[k] || y_valid !== 1'b1) begin
                errors++;
                $display("FAIL walking_one sel=%0d: y=%h v=%b expected y=%h v=1", sels[k], y, y_valid, wants[k]);
            end
        end
    endtask

    task automatic test_enable_hold();
        randomize_inputs();
        sel = 3'd3;
        d[3] = 8'hA5;
        en = 1'b1;
        tick();
        checks++;
        if (y !== 8'hA5 || y_valid !== 1'b1) begin
            errors++;
            $display("FAIL hold_capture: y=%h v=%b expected y=a5 v=1", y, y_valid);
        end
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            randomize_inputs();
            d[3] = W'($urandom);
            tick();
            checks++;
            if (y !== 8'hA5 || y_valid !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d: y=%h v=%b expected y=a5 v=0", k, y, y_valid);
            end
        end
    endtask

    task automatic test_async_reset_midstream();
        en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            randomize_inputs();
            tick();
            checks++;
            if (y !== exp_y || y_valid !== 1'b1) begin
                errors++;
                $display("FAIL stream cycle%0d: y=%h v=%b expected y=%h v=1", k, y, y_valid, exp_y);
            end
        end
        randomize_inputs();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (y !== '0 || y_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_midstream: y=%h v=%b expected y=00 v=0", y, y_valid);
        end
        exp_y = '0;
        exp_v = 1'b0;
        tick();
        rst = 1'b0;
        randomize_inputs();
        tick();
        checks++;
        if (y !== exp_y || y_valid !== 1'b1) begin
            errors++;
            $display("FAIL after_midstream_reset: y=%h v=%b expected y=%h v=1", y, y_valid, exp_y);
        end
    endtask

    task automatic test_random_regression();
        for (int k = 0; k < 1000; k++) begin
            randomize_inputs();
            en = 1'($urandom);
            tick();
            checks++;
            if (y !== exp_y || y_valid !== exp_v) begin
                errors++;
                $display("FAIL random cycle%0d: y=%h v=%b expected y=%h v=%b", k, y, y_valid, exp_y, exp_v);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_y  = '0;
        exp_v  = 1'b0;
        rst    = 1'b1;
        en     = 1'b0;
        sel    = 3'd0;
        for (int n = 0; n < 8; n++) d[n] = '0;
        @(negedge clk);
        test_reset();
        test_select_sweep();
        test_walking_one();
        test_enable_hold();
        test_async_reset_midstream();
        test_random_regression();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux8x1_reg.md
# mux8x1_reg

Registered 8-to-1 selector for the combinational-circuits library. Eight data inputs are selected by a 3-bit select (s2 MSB, s0 LSB) and the selected word is captured into an output register on the next rising clock edge. The select tree is two 4:1 stages feeding a final 2:1 stage, followed by one pipeline register with a qualifying valid flag. It drops in wherever a glitch-free, clock-aligned mux output is needed.

## Interface
- WIDTH, 1: bit width of each data input and of y.
- clk  in  1  rising-edge clock; only clock of the block.
- rst  in  1  reset, asynchronous, active-high; clears all state immediately.
- i0..i7  in  WIDTH each  data inputs; index n selected when {s2,s1,s0} = n.
- s0  in  1  select bit 0 (LSB).
- s1  in  1  select bit 1.
- s2  in  1  select bit 2 (MSB).
- en  in  1  capture enable; when high, selected input is registered this cycle.
- y  out  WIDTH  registered mux output.
- y_valid  out  1  high for exactly the cycle(s) following a capture with en=1.

## Operation
- Select index sel = {s2,s1,s0}, range 0..7.
- Stage A: lower 4:1 picks i0..i3 using {s1,s0}; upper 4:1 picks i4..i7 using {s1,s0}.
- Stage B: 2:1 picks lower (s2=0) or upper (s2=1) result; mux_out = i[sel].
- Register stage, each rising clk edge with rst low:
  - en=1: y <= mux_out; y_valid <= 1.
  - en=0: y holds previous value; y_valid <= 0.
- Selection is purely on the current-cycle sampled inputs; no history besides the output register.
- All WIDTH bits are selected together; no per-bit select.
- No arithmetic; no width conversion; y width equals input width exactly.
- X/Z on select inputs is not a supported operating condition; y content is unspecified for that cycle, y_valid still follows en.

## Timing
- Latency: 1 clock from input/select/en sampled at edge k to y/y_valid valid after edge k.
- Throughput: one new selection per clock; back-to-back en=1 cycles allowed, y_valid stays high continuously.
- Reset: rst high asynchronously forces y = 0 and y_valid = 0 without waiting for clk; both remain 0 while rst is high.
- Reset release: first capture occurs at the first rising edge with rst low and en=1.
- Reset mid-operation: any pending capture is discarded; y returns to 0, y_valid to 0.
- Simultaneous select and data change: the values present at the capturing edge are used; no glitch propagates to y.
- Combinational path i*/s*/en -> register D only; no combinational path from any input to y or y_valid.

## Test plan
- Reset: drive rst=1 with random inputs, en=1 -> y=0, y_valid=0 immediately and while held; release, next edge captures.
- Exhaustive select sweep (WIDTH=1): i0..i7 = 1,0,1,1,0,0,1,0, en=1, sel 0..7 one per cycle -> y one cycle later = 1,0,1,1,0,0,1,0, y_valid=1 throughout.
- Walking-one data (WIDTH=8): i_n = 8'h01<<n, sel=5 -> y=8'h20; sel=7 -> y=8'h80; sel=0 -> y=8'h01.
- Enable hold: capture sel=3 with i3=8'hA5, then en=0 for 3 cycles while changing i3 and sel -> y stays 8'hA5, y_valid=0.
- Async reset mid-stream: 20 cycles random i0..i7, s0..s2 with en=1, check y against i[{s2,s1,s0}] of previous cycle each cycle; assert rst between edges -> y=0, y_valid=0 before next edge.
- Random regression: 1000 cycles random data, selects and en -> y/y_valid match a one-cycle-delayed reference model every cycle.
